// File: rtl/clock_time_register.sv
// rtl/clock_time_register.sv - BCD time-of-day register with 1 Hz advance and manual set mode
module clock_time_register #(
    parameter logic [5:0] RESET_HOURS   = 6'h00,
    parameter logic [6:0] RESET_MINUTES = 7'h00
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic       i_1hz_stb,
    input  logic       i_timeset_stb,
    input  logic       i_set_hours,
    input  logic       i_set_minutes,
    output logic [5:0] o_hours,
    output logic [6:0] o_minutes,
    output logic [6:0] o_seconds,
    output logic       o_day_stb,
    output logic       o_setting
);

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [5:0] hours, hours_n;
    logic [6:0] minutes, minutes_n;
    logic [6:0] seconds, seconds_n;
    logic       day_stb, day_stb_n;

    // Two-digit BCD increment wrapping 59 -> 00.
    function automatic logic [6:0] inc_59(input logic [6:0] v);
        logic [6:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[6:4] == 3'd5) r = 7'h00;
            else                r = {v[6:4] + 3'd1, 4'd0};
        end else begin
            r = {v[6:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD increment wrapping 23 -> 00.
    function automatic logic [5:0] inc_23(input logic [5:0] v);
        logic [5:0] r;
        if (v == 6'h23)           r = 6'h00;
        else if (v[3:0] == 4'd9)  r = {v[5:4] + 2'd1, 4'd0};
        else                      r = {v[5:4], v[3:0] + 4'd1};
        return r;
    endfunction

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= RUN;
            hours   <= RESET_HOURS;
            minutes <= RESET_MINUTES;
            seconds <= 7'h00;
            day_stb <= 1'b0;
        end else begin
            state   <= state_n;
            hours   <= hours_n;
            minutes <= minutes_n;
            seconds <= seconds_n;
            day_stb <= day_stb_n;
        end
    end

    always_comb begin
        state_n   = state;
        hours_n   = hours;
        minutes_n = minutes;
        seconds_n = seconds;
        day_stb_n = 1'b0;
        if (i_en) begin
            case (state)
                RUN: begin
                    // Mode entry takes priority, so a strobe on the entry edge is dropped.
                    if (i_set_hours || i_set_minutes) begin
                        state_n   = SET;
                        seconds_n = 7'h00;
                    end else if (i_1hz_stb) begin
                        seconds_n = inc_59(seconds);
                        if (seconds == 7'h59) begin
                            minutes_n = inc_59(minutes);
                            if (minutes == 7'h59) begin
                                hours_n = inc_23(hours);
                                if (hours == 6'h23) day_stb_n = 1'b1;
                            end
                        end
                    end
                end
                SET: begin
                    if (!(i_set_hours || i_set_minutes)) begin
                        state_n = RUN;
                    end else if (i_timeset_stb) begin
                        // Fields advance independently; no carry between them.
                        if (i_set_hours)   hours_n   = inc_23(hours);
                        if (i_set_minutes) minutes_n = inc_59(minutes);
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    assign o_hours   = hours;
    assign o_minutes = minutes;
    assign o_seconds = seconds;
    assign o_day_stb = day_stb;
    assign o_setting = (state == SET);

endmodule

// File: tb/tb_clock_time_register.sv
// tb/tb_clock_time_register.sv - directed self-checking bench for clock_time_register
module tb_clock_time_register;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_en = 1'b1;
    logic       i_1hz_stb = 1'b0;
    logic       i_timeset_stb = 1'b0;
    logic       i_set_hours = 1'b0;
    logic       i_set_minutes = 1'b0;
    logic [5:0] o_hours;
    logic [6:0] o_minutes;
    logic [6:0] o_seconds;
    logic       o_day_stb;
    logic       o_setting;

    int total = 0;
    int bad   = 0;

    clock_time_register dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_en          (i_en),
        .i_1hz_stb     (i_1hz_stb),
        .i_timeset_stb (i_timeset_stb),
        .i_set_hours   (i_set_hours),
        .i_set_minutes (i_set_minutes),
        .o_hours       (o_hours),
        .o_minutes     (o_minutes),
        .o_seconds     (o_seconds),
        .o_day_stb     (o_day_stb),
        .o_setting     (o_setting)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [6:0] bcd7(input int v);
        return {3'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [19:0] now_time();
        return {o_hours, o_minutes, o_seconds};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_1hz(input int n);
        for (int i = 0; i < n; i++) begin
            i_1hz_stb = 1'b1;
            tick();
            i_1hz_stb = 1'b0;
        end
    endtask

    task automatic pulse_ts(input int n);
        for (int i = 0; i < n; i++) begin
            i_timeset_stb = 1'b1;
            tick();
            i_timeset_stb = 1'b0;
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        #3;
        total++;
        if (now_time() !== 20'h0 || o_setting !== 1'b0 || o_day_stb !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: time=%h setting=%b day=%b, need 00000 0 0", now_time(), o_setting, o_day_stb);
        end
        #4 i_reset_n = 1'b1;
        tick();
        total++;
        if (now_time() !== 20'h0) begin
            bad++;
            $display("FAIL reset_hold: time=%h need 00000", now_time());
        end
    endtask

    task automatic test_counting();
        logic [19:0] exp;
        for (int n = 1; n <= 75; n++) begin
            exp = {6'h00, bcd7(n / 60), bcd7(n % 60)};
            pulse_1hz(1);
            total++;
            if (now_time() !== exp) begin
                bad++;
                $display("FAIL count_step%0d: time=%h need %h", n, now_time(), exp);
            end
            tick();
            total++;
            if (now_time() !== exp) begin
                bad++;
                $display("FAIL count_hold%0d: time=%h need %h", n, now_time(), exp);
            end
        end
        total++;
        if (now_time() !== {6'h00, 7'h01, 7'h15}) begin
            bad++;
            $display("FAIL count_final: time=%h need 00:01:15", now_time());
        end
    endtask

    task automatic test_async_reset();
        i_set_minutes = 1'b1;
        tick();
        pulse_ts(7);
        total++;
        if (now_time() !== {6'h00, 7'h08, 7'h00} || o_setting !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_set: time=%h setting=%b need 00:08:00 1", now_time(), o_setting);
        end
        #2 i_reset_n = 1'b0;
        #1;
        total++;
        if (now_time() !== 20'h0 || o_setting !== 1'b0 || o_day_stb !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: time=%h setting=%b day=%b need 00000 0 0", now_time(), o_setting, o_day_stb);
        end
        i_set_minutes = 1'b0;
        #1 i_reset_n = 1'b1;
        pulse_1hz(1);
        total++;
        if (now_time() !== {6'h00, 7'h00, 7'h01} || o_setting !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_run: time=%h setting=%b need 00:00:01 0", now_time(), o_setting);
        end
    endtask

    task automatic test_day_rollover();
        i_reset_n = 1'b0;
        #1 i_reset_n = 1'b1;
        i_set_hours = 1'b1;
        tick();
        pulse_ts(23);
        i_set_hours = 1'b0;
        i_set_minutes = 1'b1;
        pulse_ts(59);
        i_set_minutes = 1'b0;
        tick();
        total++;
        if (now_time() !== {6'h23, 7'h59, 7'h00} || o_setting !== 1'b0) begin
            bad++;
            $display("FAIL preload: time=%h setting=%b need 23:59:00 0", now_time(), o_setting);
        end
        pulse_1hz(59);
        total++;
        if (now_time() !== {6'h23, 7'h59, 7'h59} || o_day_stb !== 1'b0) begin
            bad++;
            $display("FAIL pre_roll: time=%h day=%b need 23:59:59 0", now_time(), o_day_stb);
        end
        pulse_1hz(1);
        total++;
        if (now_time() !== 20'h0 || o_day_stb !== 1'b1) begin
            bad++;
            $display("FAIL day_roll: time=%h day=%b need 00:00:00 1", now_time(), o_day_stb);
        end
        tick();
        total++;
        if (o_day_stb !== 1'b0) begin
            bad++;
            $display("FAIL day_stb_width: day=%b need 0", o_day_stb);
        end
    endtask

    task automatic test_set_mode();
        i_set_hours = 1'b1;
        tick();
        pulse_ts(10);
        i_set_hours = 1'b0;
        i_set_minutes = 1'b1;
        pulse_ts(45);
        i_set_minutes = 1'b0;
        tick();
        pulse_1hz(37);
        total++;
        if (now_time() !== {6'h10, 7'h45, 7'h37}) begin
            bad++;
            $display("FAIL set_preload: time=%h need 10:45:37", now_time());
        end
        // Entry edge carries a timeset strobe that must be ignored.
        i_set_minutes = 1'b1;
        i_timeset_stb = 1'b1;
        tick();
        i_timeset_stb = 1'b0;
        total++;
        if (now_time() !== {6'h10, 7'h45, 7'h00} || o_setting !== 1'b1) begin
            bad++;
            $display("FAIL set_entry: time=%h setting=%b need 10:45:00 1", now_time(), o_setting);
        end
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) begin
                i_1hz_stb = 1'b1;
                pulse_ts(1);
                i_1hz_stb = 1'b0;
            end else begin
                pulse_ts(1);
                pulse_1hz(1);
            end
        end
        total++;
        if (now_time() !== {6'h10, 7'h05, 7'h00} || o_setting !== 1'b1) begin
            bad++;
            $display("FAIL set_minutes: time=%h setting=%b need 10:05:00 1", now_time(), o_setting);
        end
        // Exit edge carries a 1 Hz strobe that must be ignored.
        i_set_minutes = 1'b0;
        pulse_1hz(1);
        total++;
        if (now_time() !== {6'h10, 7'h05, 7'h00} || o_setting !== 1'b0) begin
            bad++;
            $display("FAIL set_exit: time=%h setting=%b need 10:05:00 0", now_time(), o_setting);
        end
        pulse_1hz(1);
        total++;
        if (now_time() !== {6'h10, 7'h05, 7'h01}) begin
            bad++;
            $display("FAIL resume: time=%h need 10:05:01", now_time());
        end
    endtask

    task automatic test_both_set();
        i_set_hours = 1'b1;
        tick();
        pulse_ts(12);
        i_set_hours = 1'b0;
        i_set_minutes = 1'b1;
        pulse_ts(53);
        total++;
        if (now_time() !== {6'h22, 7'h58, 7'h00}) begin
            bad++;
            $display("FAIL both_preload: time=%h need 22:58:00", now_time());
        end
        i_set_hours = 1'b1;
        pulse_ts(1);
        total++;
        if (now_time() !== {6'h23, 7'h59, 7'h00} || o_day_stb !== 1'b0) begin
            bad++;
            $display("FAIL both_step1: time=%h day=%b need 23:59:00 0", now_time(), o_day_stb);
        end
        pulse_ts(1);
        total++;
        if (now_time() !== 20'h0 || o_day_stb !== 1'b0) begin
            bad++;
            $display("FAIL both_wrap: time=%h day=%b need 00:00:00 0", now_time(), o_day_stb);
        end
        tick();
        total++;
        if (o_day_stb !== 1'b0) begin
            bad++;
            $display("FAIL both_no_day: day=%b need 0", o_day_stb);
        end
        i_set_hours = 1'b0;
        i_set_minutes = 1'b0;
        tick();
        pulse_1hz(1);
        total++;
        if (now_time() !== {6'h00, 7'h00, 7'h01} || o_setting !== 1'b0) begin
            bad++;
            $display("FAIL both_release: time=%h setting=%b need 00:00:01 0", now_time(), o_setting);
        end
    endtask

    task automatic test_enable();
        i_en = 1'b0;
        pulse_1hz(10);
        i_set_hours = 1'b1;
        pulse_ts(2);
        total++;
        if (now_time() !== {6'h00, 7'h00, 7'h01} || o_setting !== 1'b0) begin
            bad++;
            $display("FAIL en_frozen: time=%h setting=%b need 00:00:01 0", now_time(), o_setting);
        end
        i_set_hours = 1'b0;
        i_en = 1'b1;
        pulse_1hz(1);
        total++;
        if (now_time() !== {6'h00, 7'h00, 7'h02}) begin
            bad++;
            $display("FAIL en_resume: time=%h need 00:00:02", now_time());
        end
        tick();
        total++;
        if (now_time() !== {6'h00, 7'h00, 7'h02}) begin
            bad++;
            $display("FAIL en_no_queue: time=%h need 00:00:02", now_time());
        end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_async_reset();
        test_day_rollover();
        test_set_mode();
        test_both_set();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
